prescaled_counter: RTL and testbench



---
 rtl/tick_divider.sv | 35 +++
 rtl/prescaled_counter.sv | 100 ++++++++++
 tb/tb_prescaled_counter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/tick_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_divider : clock-enable prescaler, one step every DIVIDER enabled edges
// Revision 1.0
// ---------------------------------------------------------------------------
module tick_divider #(
  parameter int DIV_WIDTH = 10,
  parameter int DIVIDER   = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(DIVIDER - 1);

  logic [DIV_WIDTH-1:0] r_div_cnt;

  // Step is combinational so the consumer acts on the same edge the period ends.
  assign step = en && (r_div_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_div_cnt <= '0;
    end else if (step) begin
      r_div_cnt <= '0;
    end else if (en) begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prescaled_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prescaled_counter : up/down counter with load, pause, wrap/saturate modes,
//                     advanced by a clock-enable prescaler in the clk domain
// Revision 1.0
// ---------------------------------------------------------------------------
module prescaled_counter #(
  parameter int COUNT_WIDTH = 4,
  parameter int DIVIDER     = 1000,
  parameter int DIV_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   up,
  input  logic                   sat,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   tick,
  output logic                   wrapped,
  output logic                   at_limit
);

  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = '1;

  if ((DIVIDER < 1) || (64'(DIVIDER) > (64'd1 << DIV_WIDTH))) begin : g_bad_divider
    $error("prescaled_counter: DIVIDER %0d outside 1..2**%0d", DIVIDER, DIV_WIDTH);
  end

  logic                   w_step;
  logic                   w_at_max;
  logic                   w_at_min;
  logic                   w_wrap;
  logic [COUNT_WIDTH-1:0] w_next_count;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_tick;
  logic                   r_wrapped;

  tick_divider #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIVIDER   (DIVIDER)
  ) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .step (w_step)
  );

  assign w_at_max = (r_count == MAX_COUNT);
  assign w_at_min = (r_count == '0);

  // Value the count takes if this edge turns out to be a step.
  always_comb begin
    w_next_count = r_count;
    w_wrap       = 1'b0;
    if (up) begin
      if (!w_at_max) begin
        w_next_count = r_count + 1'b1;
      end else if (!sat) begin
        w_next_count = '0;
        w_wrap       = 1'b1;
      end
    end else begin
      if (!w_at_min) begin
        w_next_count = r_count - 1'b1;
      end else if (!sat) begin
        w_next_count = MAX_COUNT;
        w_wrap       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_tick    <= 1'b0;
      r_wrapped <= 1'b0;
    end else if (load) begin
      r_count   <= load_value;
      r_tick    <= 1'b0;
      r_wrapped <= 1'b0;
    end else if (w_step) begin
      r_count   <= w_next_count;
      r_tick    <= 1'b1;
      r_wrapped <= w_wrap;
    end else begin
      r_tick    <= 1'b0;
      r_wrapped <= 1'b0;
    end
  end

  assign count    = r_count;
  assign tick     = r_tick;
  assign wrapped  = r_wrapped;
  assign at_limit = up ? w_at_max : w_at_min;

endmodule
`default_nettype wire

// File: tb/tb_prescaled_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_prescaled_counter : table/scoreboard bench over DIVIDER = 3, 4 and 1
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_prescaled_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, up, sat, load;
    logic [3:0] lv;
    logic [3:0] ec;
    logic       et, ew, ea;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] c;
    logic       t, w, a;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // DUT A: DIVIDER=3
  logic a_rst = 1'b1, a_en = 1'b1, a_up = 1'b1, a_sat = 1'b0, a_load = 1'b0;
  logic [3:0] a_lv = 4'd0, a_count;
  logic a_tick, a_wrapped, a_at_limit;
  // DUT B: DIVIDER=4
  logic b_rst = 1'b1, b_en = 1'b1, b_up = 1'b1, b_sat = 1'b0, b_load = 1'b0;
  logic [3:0] b_lv = 4'd0, b_count;
  logic b_tick, b_wrapped, b_at_limit;
  // DUT C: DIVIDER=1
  logic c_rst = 1'b1, c_en = 1'b1, c_up = 1'b1, c_sat = 1'b0, c_load = 1'b0;
  logic [3:0] c_lv = 4'd0, c_count;
  logic c_tick, c_wrapped, c_at_limit;

  prescaled_counter #(.COUNT_WIDTH(4), .DIVIDER(3), .DIV_WIDTH(10)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .sat(a_sat), .load(a_load),
    .load_value(a_lv), .count(a_count), .tick(a_tick), .wrapped(a_wrapped),
    .at_limit(a_at_limit));

  prescaled_counter #(.COUNT_WIDTH(4), .DIVIDER(4), .DIV_WIDTH(10)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .sat(b_sat), .load(b_load),
    .load_value(b_lv), .count(b_count), .tick(b_tick), .wrapped(b_wrapped),
    .at_limit(b_at_limit));

  prescaled_counter #(.COUNT_WIDTH(4), .DIVIDER(1), .DIV_WIDTH(10)) dut_c (
    .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .sat(c_sat), .load(c_load),
    .load_value(c_lv), .count(c_count), .tick(c_tick), .wrapped(c_wrapped),
    .at_limit(c_at_limit));

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic e, input logic u, input logic s,
                              input logic l, input logic [3:0] lv, input logic [3:0] c,
                              input logic t, input logic w, input logic a);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.sat = s; v.load = l; v.lv = lv;
    v.ec = c; v.et = t; v.ew = w; v.ea = a;
    vecs.push_back(v);
  endfunction

  // Drive one cycle on DUT A, queue the expectation, compare after the edge.
  task automatic cycle_a(input logic r, input logic e, input logic u, input logic s,
                         input logic l, input logic [3:0] lv, input exp_t ex);
    exp_t got;
    a_rst = r; a_en = e; a_up = u; a_sat = s; a_load = l; a_lv = lv;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("a_count",    got.idx, int'(a_count),    int'(got.c));
    chk("a_tick",     got.idx, int'(a_tick),     int'(got.t));
    chk("a_wrapped",  got.idx, int'(a_wrapped),  int'(got.w));
    chk("a_at_limit", got.idx, int'(a_at_limit), int'(got.a));
  endtask

  task automatic tick_clk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t ex;
    int mc, md;
    logic mt, mw, ma;
    logic r, e, u, s, l;
    logic [3:0] lv;

    //   rst en up sat ld  lv     count  tk wr at
    add(1, 1, 1, 0, 0, 4'd0,  4'd0,  0, 0, 0);
    add(1, 1, 1, 0, 0, 4'd0,  4'd0,  0, 0, 0);
    add(0, 1, 1, 0, 0, 4'd0,  4'd0,  0, 0, 0);
    add(0, 1, 1, 0, 0, 4'd0,  4'd0,  0, 0, 0);
    add(0, 1, 1, 0, 0, 4'd0,  4'd1,  1, 0, 0);
    add(0, 1, 1, 0, 0, 4'd0,  4'd1,  0, 0, 0);
    add(0, 1, 1, 0, 0, 4'd0,  4'd1,  0, 0, 0);
    add(0, 1, 1, 0, 0, 4'd0,  4'd2,  1, 0, 0);
    add(0, 1, 1, 0, 1, 4'd14, 4'd14, 0, 0, 0);
    add(0, 1, 1, 0, 0, 4'd0,  4'd14, 0, 0, 0);
    add(0, 1, 1, 0, 0, 4'd0,  4'd14, 0, 0, 0);
    add(0, 1, 1, 0, 0, 4'd0,  4'd15, 1, 0, 1);
    add(0, 1, 1, 0, 0, 4'd0,  4'd15, 0, 0, 1);
    add(0, 1, 1, 0, 0, 4'd0,  4'd15, 0, 0, 1);
    add(0, 1, 1, 0, 0, 4'd0,  4'd0,  1, 1, 0);
    add(0, 1, 1, 1, 1, 4'd14, 4'd14, 0, 0, 0);
    add(0, 1, 1, 1, 0, 4'd0,  4'd14, 0, 0, 0);
    add(0, 1, 1, 1, 0, 4'd0,  4'd14, 0, 0, 0);
    add(0, 1, 1, 1, 0, 4'd0,  4'd15, 1, 0, 1);
    add(0, 1, 1, 1, 0, 4'd0,  4'd15, 0, 0, 1);
    add(0, 1, 1, 1, 0, 4'd0,  4'd15, 0, 0, 1);
    add(0, 1, 1, 1, 0, 4'd0,  4'd15, 1, 0, 1);
    add(0, 1, 1, 1, 0, 4'd0,  4'd15, 0, 0, 1);
    add(0, 1, 1, 1, 0, 4'd0,  4'd15, 0, 0, 1);
    add(0, 1, 0, 1, 0, 4'd0,  4'd14, 1, 0, 0);
    add(0, 1, 0, 0, 1, 4'd1,  4'd1,  0, 0, 0);
    add(0, 1, 0, 0, 0, 4'd0,  4'd1,  0, 0, 0);
    add(0, 1, 0, 0, 0, 4'd0,  4'd1,  0, 0, 0);
    add(0, 1, 0, 0, 0, 4'd0,  4'd0,  1, 0, 1);
    add(0, 1, 0, 0, 0, 4'd0,  4'd0,  0, 0, 1);
    add(0, 1, 0, 0, 0, 4'd0,  4'd0,  0, 0, 1);
    add(0, 1, 0, 0, 0, 4'd0,  4'd15, 1, 1, 0);
    add(0, 1, 0, 0, 0, 4'd0,  4'd15, 0, 0, 0);
    add(0, 1, 0, 0, 0, 4'd0,  4'd15, 0, 0, 0);
    add(0, 1, 0, 0, 1, 4'd9,  4'd9,  0, 0, 0);
    add(1, 1, 0, 0, 1, 4'd5,  4'd0,  0, 0, 1);
    add(0, 0, 0, 0, 0, 4'd0,  4'd0,  0, 0, 1);
    add(0, 1, 0, 0, 0, 4'd0,  4'd0,  0, 0, 1);
    add(0, 1, 0, 0, 0, 4'd0,  4'd0,  0, 0, 1);
    add(0, 1, 0, 0, 0, 4'd0,  4'd15, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      ex.idx = i; ex.c = vecs[i].ec; ex.t = vecs[i].et; ex.w = vecs[i].ew; ex.a = vecs[i].ea;
      cycle_a(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].sat, vecs[i].load, vecs[i].lv, ex);
    end

    // Randomised traffic on DUT A against a behavioural model.
    mc = 0; md = 0;
    for (int i = 0; i < 300; i++) begin
      r  = (i == 0) || ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      lv = 4'($urandom_range(0, 15));
      mt = 1'b0; mw = 1'b0;
      if (r) begin
        mc = 0; md = 0;
      end else if (l) begin
        mc = int'(lv); md = 0;
      end else if (e && md == 2) begin
        md = 0; mt = 1'b1;
        if (u) begin
          if (mc == 15) begin
            if (!s) begin mc = 0; mw = 1'b1; end
          end else mc = mc + 1;
        end else begin
          if (mc == 0) begin
            if (!s) begin mc = 15; mw = 1'b1; end
          end else mc = mc - 1;
        end
      end else if (e) begin
        md = md + 1;
      end
      ma = u ? (mc == 15) : (mc == 0);
      ex.idx = 1000 + i; ex.c = 4'(mc); ex.t = mt; ex.w = mw; ex.a = ma;
      cycle_a(r, e, u, s, l, lv, ex);
    end
    chk("scoreboard_empty", 0, sb.size(), 0);

    // DIVIDER=4: pause with the prescaler at 2, resume needs exactly 2 more edges.
    b_rst = 1'b1; b_en = 1'b1;
    tick_clk();
    chk("b_reset_count", 0, int'(b_count), 0);
    chk("b_reset_at_limit", 0, int'(b_at_limit), 0);
    b_rst = 1'b0;
    tick_clk();
    tick_clk();
    chk("b_pre_pause_count", 0, int'(b_count), 0);
    b_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick_clk();
      chk("b_pause_count", k, int'(b_count), 0);
      chk("b_pause_tick", k, int'(b_tick), 0);
    end
    b_en = 1'b1;
    tick_clk();
    chk("b_resume1_count", 0, int'(b_count), 0);
    chk("b_resume1_tick", 0, int'(b_tick), 0);
    tick_clk();
    chk("b_resume2_count", 0, int'(b_count), 1);
    chk("b_resume2_tick", 0, int'(b_tick), 1);
    for (int k = 0; k < 3; k++) begin
      tick_clk();
      chk("b_period_tick", k, int'(b_tick), 0);
    end
    tick_clk();
    chk("b_period_count", 0, int'(b_count), 2);
    chk("b_period_tick", 3, int'(b_tick), 1);

    // DIVIDER=1: every enabled edge steps, tick held high.
    c_rst = 1'b1; c_en = 1'b1; c_up = 1'b1; c_sat = 1'b0;
    tick_clk();
    chk("c_reset_count", 0, int'(c_count), 0);
    c_rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick_clk();
      chk("c_count", k, int'(c_count), k % 16);
      chk("c_tick", k, int'(c_tick), 1);
      chk("c_wrapped", k, int'(c_wrapped), int'(k % 16 == 0));
    end
    c_load = 1'b1; c_lv = 4'd9;
    tick_clk();
    chk("c_load_count", 0, int'(c_count), 9);
    chk("c_load_tick", 0, int'(c_tick), 0);
    c_load = 1'b0;
    tick_clk();
    chk("c_after_load_count", 0, int'(c_count), 10);
    chk("c_after_load_tick", 0, int'(c_tick), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
